// File: rtl/signed_search_ctrl_pkg.sv
// Shared encodings for the signed compare-interface search controller.
// Holds FSM state codes, responder flag codes and the default timeout.
package signed_search_ctrl_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Flags packed as {AgtB, AeqB, AltB}
    localparam logic [2:0] RESP_GT = 3'b100;
    localparam logic [2:0] RESP_EQ = 3'b010;
    localparam logic [2:0] RESP_LT = 3'b001;

    localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/signed_search_ctrl_if.sv
// Compare bus between the search initiator (master) and a compare responder (slave).
interface signed_search_ctrl_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] guess;
    logic             query_valid;
    logic             resp_valid;
    logic             AgtB;
    logic             AeqB;
    logic             AltB;

    modport master (
        output guess, query_valid,
        input  resp_valid, AgtB, AeqB, AltB
    );

    modport slave (
        input  guess, query_valid,
        output resp_valid, AgtB, AeqB, AltB
    );
endinterface

// File: rtl/signed_search_ctrl_mid_calc.sv
// Combinational floor((lo+hi)/2) on signed WIDTH+1-bit bounds.
// The sum is widened by one bit so the midpoint never overflows.
module signed_mid_calc #(
    parameter int WIDTH = 4
) (
    input  logic signed [WIDTH:0] lo,
    input  logic signed [WIDTH:0] hi,
    output logic signed [WIDTH:0] mid
);
    logic signed [WIDTH+1:0] sum;
    logic                    unused_lsb;

    always_comb begin
        sum        = {lo[WIDTH], lo} + {hi[WIDTH], hi};
        // Dropping the LSB of a two's-complement sum is an arithmetic shift (floor)
        mid        = sum[WIDTH+1:1];
        unused_lsb = sum[0];
    end
endmodule

// File: rtl/signed_search_ctrl.sv
// Binary-search initiator: drives guesses on the compare bus and narrows
// signed [lo,hi] bounds until the responder reports equality or an error.
module signed_search_ctrl
    import signed_search_ctrl_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    signed_search_ctrl_if.master      cmp,
    output logic                      busy,
    output logic                      done,
    output logic                      found,
    output logic [WIDTH-1:0]          result,
    output logic [2:0]                num_queries,
    output logic                      error
);
    localparam int MAXQ = WIDTH + 1;
    localparam int QW   = ($clog2(MAXQ + 1) > 3) ? $clog2(MAXQ + 1) : 3;
    localparam int TW   = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef logic signed [WIDTH:0] bound_t;
    localparam bound_t LO_INIT = bound_t'(-(1 <<< (WIDTH - 1)));
    localparam bound_t HI_INIT = bound_t'((1 <<< (WIDTH - 1)) - 1);

    if (WIDTH < 2 || WIDTH > 8) begin : g_bad_width
        $error("signed_search_ctrl: WIDTH must be 2..8");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("signed_search_ctrl: TIMEOUT must be >= 1");
    end

    logic [1:0]       state_q, state_d;
    bound_t           lo_q, lo_d, hi_q, hi_d;
    bound_t           mid, lo_inc, hi_dec, lo_n, hi_n;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic             qv_q, qv_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             found_q, found_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [QW-1:0]    nq_q, nq_d;
    logic             err_q, err_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [2:0]       flags;

    signed_mid_calc #(.WIDTH(WIDTH)) u_mid (
        .lo  (lo_q),
        .hi  (hi_q),
        .mid (mid)
    );

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        guess_d  = guess_q;
        qv_d     = qv_q;
        found_d  = found_q;
        result_d = result_q;
        nq_d     = nq_q;
        err_d    = err_q;
        tmo_d    = tmo_q;
        flags    = {cmp.AgtB, cmp.AeqB, cmp.AltB};
        lo_inc   = mid + bound_t'(1);
        hi_dec   = mid - bound_t'(1);
        lo_n     = (flags == RESP_LT) ? lo_inc : lo_q;
        hi_n     = (flags == RESP_GT) ? hi_dec : hi_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lo_d     = LO_INIT;
                    hi_d     = HI_INIT;
                    nq_d     = '0;
                    err_d    = 1'b0;
                    found_d  = 1'b0;
                    result_d = '0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                guess_d = mid[WIDTH-1:0];
                qv_d    = 1'b1;
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A response on the expiry cycle is checked first, so it wins
                if (cmp.resp_valid) begin
                    qv_d = 1'b0;
                    nq_d = nq_q + QW'(1);
                    case (flags)
                        RESP_EQ: begin
                            found_d  = 1'b1;
                            result_d = mid[WIDTH-1:0];
                            state_d  = S_DONE;
                        end
                        RESP_GT, RESP_LT: begin
                            lo_d = lo_n;
                            hi_d = hi_n;
                            if (lo_n > hi_n || nq_d == QW'(MAXQ)) begin
                                err_d   = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                state_d = S_ISSUE;
                            end
                        end
                        default: begin
                            err_d   = 1'b1;
                            found_d = 1'b0;
                            state_d = S_DONE;
                        end
                    endcase
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    qv_d    = 1'b0;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            guess_q  <= '0;
            qv_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            result_q <= '0;
            nq_q     <= '0;
            err_q    <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            guess_q  <= guess_d;
            qv_q     <= qv_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            found_q  <= found_d;
            result_q <= result_d;
            nq_q     <= nq_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
        end
    end

    assign cmp.guess       = guess_q;
    assign cmp.query_valid = qv_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign found           = found_q;
    assign result          = result_q;
    assign num_queries     = nq_q[2:0];
    assign error           = err_q;
endmodule
